// File: rtl/niosii_onchip_mem_burst_adapter_if.sv
// Avalon-MM bursting slave bundle between the Nios II data master and the
// on-chip RAM burst adapter.
//   master : drives address/byteenable/burstcount/read/write/writedata,
//            observes waitrequest/readdata/readdatavalid
//   slave  : the adapter side (mirror image)
interface niosii_onchip_mem_burst_adapter_if #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
) ();
  logic [ADDR_W-1:0]   avs_address;
  logic [DATA_W/8-1:0] avs_byteenable;
  logic [BURST_W-1:0]  avs_burstcount;
  logic                avs_read;
  logic                avs_write;
  logic [DATA_W-1:0]   avs_writedata;
  logic                avs_waitrequest;
  logic [DATA_W-1:0]   avs_readdata;
  logic                avs_readdatavalid;

  modport master (
    output avs_address, avs_byteenable, avs_burstcount, avs_read, avs_write, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );
  modport slave (
    input  avs_address, avs_byteenable, avs_burstcount, avs_read, avs_write, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/niosii_onchip_mem_burst_adapter.sv
// Burst-to-single-beat adapter in front of the single-port on-chip RAM
// (1-cycle read latency, unregistered q).
//   clk, reset   : clock, synchronous active-high reset
//   reset_req    : freezes the whole block (waitrequest high, no RAM access)
//   avs          : Avalon-MM bursting slave (interface, slave modport)
//   mem_*        : RAM address/byteenable/chipselect/write/writedata/clken, q in
//   oor_flag     : sticky, set by any beat addressing at or beyond DEPTH
// Reads return with a fixed 2-cycle latency from issue; out-of-range reads
// still return a beat, with data forced to zero.
module niosii_onchip_mem_burst_adapter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 12000,
  parameter int BURST_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  niosii_onchip_mem_burst_adapter_if.slave avs,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                oor_flag
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d, last_addr_q;
  logic [BURST_W-1:0]  rem_q, rem_d, bc_m1;
  logic                beat_vld, beat_wr, beat_in_rng;
  logic [ADDR_W-1:0]   beat_addr;
  logic [2:1]          vld_pipe;   // [1]=read pending at RAM, [2]=readdatavalid
  logic                pend_oor;
  logic [DATA_W-1:0]   rdata_q;
  logic                oor_q;

  // burstcount 0 is a single beat
  assign bc_m1 = (avs.avs_burstcount == '0) ? '0 : avs.avs_burstcount - 1'b1;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    beat_vld   = 1'b0;
    beat_wr    = 1'b0;
    beat_addr  = cur_addr_q;
    if (!reset && !reset_req) begin
      unique case (state_q)
        IDLE: begin
          // write has priority when both commands are presented
          if (avs.avs_write || avs.avs_read) begin
            beat_vld   = 1'b1;
            beat_wr    = avs.avs_write;
            beat_addr  = avs.avs_address;
            cur_addr_d = avs.avs_address + 1'b1;
            rem_d      = bc_m1;
            if (bc_m1 != '0) state_d = avs.avs_write ? WBURST : RBURST;
          end
        end
        WBURST: begin
          if (avs.avs_write) begin
            beat_vld   = 1'b1;
            beat_wr    = 1'b1;
            cur_addr_d = cur_addr_q + 1'b1;
            rem_d      = rem_q - 1'b1;
            if (rem_q == BURST_W'(1)) state_d = IDLE;
          end
        end
        RBURST: begin
          beat_vld   = 1'b1;
          cur_addr_d = cur_addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
          if (rem_q == BURST_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign beat_in_rng = ({1'b0, beat_addr} < DEPTH_L);

  // When no beat is issued the RAM keeps seeing the last issued address, so
  // its registered q stays valid for a read that is held across reset_req.
  assign mem_address    = beat_vld ? beat_addr : last_addr_q;
  assign mem_byteenable = beat_wr ? avs.avs_byteenable : '1;
  assign mem_writedata  = avs.avs_writedata;
  assign mem_chipselect = beat_vld & beat_in_rng;
  assign mem_write      = beat_vld & beat_wr & beat_in_rng;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      rem_q       <= '0;
      vld_pipe    <= '0;
      pend_oor    <= 1'b0;
      rdata_q     <= '0;
      oor_q       <= 1'b0;
    end else if (!reset_req) begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      if (beat_vld) last_addr_q <= beat_addr;
      vld_pipe[1] <= beat_vld & ~beat_wr;
      vld_pipe[2] <= vld_pipe[1];
      pend_oor    <= ~beat_in_rng;
      if (vld_pipe[1]) rdata_q <= pend_oor ? '0 : mem_readdata;
      if (beat_vld && !beat_in_rng) oor_q <= 1'b1;
    end
  end

  // A held valid must not be seen more than once, so mask it while frozen.
  assign avs.avs_readdatavalid = vld_pipe[2] & ~reset_req & ~reset;
  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_waitrequest   = reset_req | (state_q == RBURST);
  assign oor_flag              = oor_q;
endmodule
